// File: rtl/icache.sv
// icache: direct-mapped instruction cache, one-cycle hit, whole-block miss fill from MC.
// Optional hit/miss counters enabled by defining ICACHE_HIT_CNT_EN.
module icache #(
  parameter int ADDR_WIDTH    = 32,
  parameter int BLK_WORDS_LOG = 2,
  parameter int INDEX_WIDTH   = 6
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              rdy_in,
  input  logic                              clear_in,
  input  logic                              IF2IC_en,
  input  logic [ADDR_WIDTH-1:0]             IF2IC_addr,
  output logic                              IC2IF_en,
  output logic [31:0]                       IC2IF_inst,
  output logic                              IC2MC_en,
  output logic [ADDR_WIDTH-1:0]             IC2MC_addr,
  input  logic                              MC2IC_en,
  input  logic [(32<<BLK_WORDS_LOG)-1:0]    MC2IC_block
`ifdef ICACHE_HIT_CNT_EN
  ,
  output logic [31:0]                       hit_cnt,
  output logic [31:0]                       miss_cnt
`endif
);
  localparam int OW    = BLK_WORDS_LOG;
  localparam int OL    = OW + 2;
  localparam int TW    = ADDR_WIDTH - OL - INDEX_WIDTH;
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int BW    = 32 << OW;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                  state, state_d;
  logic                    discard, discard_d;
  logic                    if_en_d, mc_en_d;
  logic [31:0]             inst_d;
  logic [ADDR_WIDTH-1:0]   mc_addr_d;
  logic [OW-1:0]           lat_off, lat_off_d, off;
  logic [INDEX_WIDTH-1:0]  idx, fidx;
  logic [TW-1:0]           tag, ftag;
  logic [LINES-1:0]        valid;
  logic [TW-1:0]           tag_mem  [LINES];
  logic [BW-1:0]           data_mem [LINES];
  logic                    hit, accept, fill, unused;

  assign off    = IF2IC_addr[OL-1:2];
  assign idx    = IF2IC_addr[OL +: INDEX_WIDTH];
  assign tag    = IF2IC_addr[ADDR_WIDTH-1 -: TW];
  assign fidx   = IC2MC_addr[OL +: INDEX_WIDTH];
  assign ftag   = IC2MC_addr[ADDR_WIDTH-1 -: TW];
  assign hit    = valid[idx] && tag_mem[idx] == tag;
  assign accept = state == IDLE && IF2IC_en && !clear_in;
  assign fill   = state == MISS && MC2IC_en;
  assign unused = ^IF2IC_addr[1:0];

  always_comb begin
    state_d   = state;
    discard_d = discard;
    if_en_d   = 1'b0;
    inst_d    = IC2IF_inst;
    mc_en_d   = IC2MC_en;
    mc_addr_d = IC2MC_addr;
    lat_off_d = lat_off;
    if (accept && hit) begin
      if_en_d = 1'b1;
      inst_d  = data_mem[idx][{off, 5'b0} +: 32];
    end else if (accept) begin
      state_d   = MISS;
      mc_en_d   = 1'b1;
      mc_addr_d = {IF2IC_addr[ADDR_WIDTH-1:OL], {OL{1'b0}}};
      lat_off_d = off;
      discard_d = 1'b0;
    end
    if (state == MISS) begin
      discard_d = discard | clear_in;
      if (MC2IC_en) begin
        state_d = IDLE;
        mc_en_d = 1'b0;
        if_en_d = !(discard | clear_in);
        inst_d  = if_en_d ? MC2IC_block[{lat_off, 5'b0} +: 32] : IC2IF_inst;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      discard    <= 1'b0;
      IC2IF_en   <= 1'b0;
      IC2IF_inst <= '0;
      IC2MC_en   <= 1'b0;
      IC2MC_addr <= '0;
      lat_off    <= '0;
      valid      <= '0;
    end else if (rdy_in) begin
      state      <= state_d;
      discard    <= discard_d;
      IC2IF_en   <= if_en_d;
      IC2IF_inst <= inst_d;
      IC2MC_en   <= mc_en_d;
      IC2MC_addr <= mc_addr_d;
      lat_off    <= lat_off_d;
      if (fill) valid[fidx] <= 1'b1;
    end
  end

  // line storage needs no reset; valid bits gate every use
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && fill) begin
      tag_mem[fidx]  <= ftag;
      data_mem[fidx] <= MC2IC_block;
    end
  end

`ifdef ICACHE_HIT_CNT_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rdy_in && accept) begin
      hit_cnt  <= hit_cnt + {31'b0, hit};
      miss_cnt <= miss_cnt + {31'b0, !hit};
    end
  end
`endif
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed self-checking bench for icache (default parameters).
module tb_icache;
  logic         clk_in = 1'b0, rst_in, rdy_in, clear_in, IF2IC_en, MC2IC_en;
  logic [31:0]  IF2IC_addr, IC2IF_inst, IC2MC_addr;
  logic         IC2IF_en, IC2MC_en;
  logic [127:0] MC2IC_block;
  int           n_cmp = 0, n_bad = 0;

  localparam logic [127:0] B0 = {32'h33333333, 32'h22222222, 32'h00500093, 32'h11111111};

  icache dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .IF2IC_en(IF2IC_en), .IF2IC_addr(IF2IC_addr),
    .IC2IF_en(IC2IF_en), .IC2IF_inst(IC2IF_inst),
    .IC2MC_en(IC2MC_en), .IC2MC_addr(IC2MC_addr),
    .MC2IC_en(MC2IC_en), .MC2IC_block(MC2IC_block)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [127:0] mkblk(input logic [31:0] base);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[32*i +: 32] = base + 32'hA0000000 + 32'(i);
    return b;
  endfunction

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tg, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] a);
    IF2IC_en = 1'b1; IF2IC_addr = a;
    cyc();
    IF2IC_en = 1'b0;
  endtask

  task automatic serve(input logic [127:0] b);
    MC2IC_en = 1'b1; MC2IC_block = b;
    cyc();
    MC2IC_en = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; IF2IC_en = 1'b0; IF2IC_addr = '0;
    MC2IC_en = 1'b0; MC2IC_block = '0;
    cyc(); cyc();
    rst_in = 1'b0;
    chk("rst_if_en", 32'(IC2IF_en), 0);
    chk("rst_inst", IC2IF_inst, 0);
    chk("rst_mc_en", 32'(IC2MC_en), 0);
    chk("rst_mc_addr", IC2MC_addr, 0);

    // cold fetch
    fetch(32'h4);
    chk("cold_mc_en", 32'(IC2MC_en), 1);
    chk("cold_mc_addr", IC2MC_addr, 32'h0);
    chk("cold_no_if", 32'(IC2IF_en), 0);
    cyc();
    chk("cold_mc_hold", 32'(IC2MC_en), 1);
    serve(B0);
    chk("cold_if_en", 32'(IC2IF_en), 1);
    chk("cold_inst", IC2IF_inst, 32'h00500093);
    chk("cold_mc_drop", 32'(IC2MC_en), 0);
    cyc();
    chk("cold_pulse_end", 32'(IC2IF_en), 0);

    // hits, back-to-back
    fetch(32'hC);
    chk("hit_en", 32'(IC2IF_en), 1);
    chk("hit_inst", IC2IF_inst, 32'h33333333);
    chk("hit_no_mc", 32'(IC2MC_en), 0);
    IF2IC_en = 1'b1; IF2IC_addr = 32'h0; cyc();
    chk("b2b0_en", 32'(IC2IF_en), 1);
    chk("b2b0_inst", IC2IF_inst, 32'h11111111);
    IF2IC_addr = 32'h4; cyc();
    chk("b2b1_en", 32'(IC2IF_en), 1);
    chk("b2b1_inst", IC2IF_inst, 32'h00500093);
    IF2IC_addr = 32'h8; cyc();
    IF2IC_en = 1'b0;
    chk("b2b2_en", 32'(IC2IF_en), 1);
    chk("b2b2_inst", IC2IF_inst, 32'h22222222);
    cyc();
    chk("b2b_end", 32'(IC2IF_en), 0);

    // conflict eviction
    fetch(32'h400);
    chk("evict_mc_en", 32'(IC2MC_en), 1);
    chk("evict_mc_addr", IC2MC_addr, 32'h400);
    serve(mkblk(32'h400));
    chk("evict_inst", IC2IF_inst, 32'hA0000400);
    fetch(32'h0);
    chk("refetch_miss", 32'(IC2MC_en), 1);
    chk("refetch_addr", IC2MC_addr, 32'h0);
    chk("refetch_no_if", 32'(IC2IF_en), 0);
    serve(B0);
    chk("refetch_inst", IC2IF_inst, 32'h11111111);

    // clear during miss, then clear in idle
    fetch(32'h10);
    chk("clr_mc_addr", IC2MC_addr, 32'h10);
    clear_in = 1'b1; cyc(); clear_in = 1'b0;
    chk("clr_mc_hold", 32'(IC2MC_en), 1);
    serve(mkblk(32'h10));
    chk("clr_no_if", 32'(IC2IF_en), 0);
    chk("clr_mc_drop", 32'(IC2MC_en), 0);
    fetch(32'h14);
    chk("clr_hit_en", 32'(IC2IF_en), 1);
    chk("clr_hit_inst", IC2IF_inst, 32'hA0000011);
    clear_in = 1'b1; fetch(32'h0); clear_in = 1'b0;
    chk("idle_clr_supp", 32'(IC2IF_en), 0);
    chk("idle_clr_no_mc", 32'(IC2MC_en), 0);

    // rdy stall mid-hit
    fetch(32'h18);
    chk("stall_hit_en", 32'(IC2IF_en), 1);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_hit_hold", 32'(IC2IF_en), 1);
    end
    rdy_in = 1'b1; cyc();
    chk("stall_hit_single", 32'(IC2IF_en), 0);
    chk("stall_hit_inst", IC2IF_inst, 32'hA0000012);

    // rdy stall mid-miss
    fetch(32'h20);
    chk("stall_miss_addr", IC2MC_addr, 32'h20);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_miss_hold", 32'(IC2MC_en), 1);
    end
    rdy_in = 1'b1;
    serve(mkblk(32'h20));
    chk("stall_miss_if", 32'(IC2IF_en), 1);
    chk("stall_miss_inst", IC2IF_inst, 32'hA0000020);
    cyc();
    chk("stall_miss_single", 32'(IC2IF_en), 0);

    // reset mid-miss
    fetch(32'h30);
    chk("rstm_mc_en", 32'(IC2MC_en), 1);
    rst_in = 1'b1; cyc(); rst_in = 1'b0;
    chk("rstm_mc_drop", 32'(IC2MC_en), 0);
    fetch(32'h0);
    chk("rstm_refill", 32'(IC2MC_en), 1);
    chk("rstm_no_hit", 32'(IC2IF_en), 0);
    serve(B0);
    chk("rstm_inst", IC2IF_inst, 32'h11111111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
